// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RISC-V control path: opcodes, state codes,
// datapath mux selects and the control-word layout.
package riscv_pkg;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_EXEC_R = 4'd2,
    ST_EXEC_I = 4'd3,
    ST_ADDR   = 4'd4,
    ST_MEM_RD = 4'd5,
    ST_MEM_WB = 4'd6,
    ST_MEM_WR = 4'd7,
    ST_ALU_WB = 4'd8,
    ST_BRANCH = 4'd9,
    ST_JAL    = 4'd10,
    ST_JALR   = 4'd11,
    ST_LUI    = 4'd12,
    ST_TRAP   = 4'd15
  } state_e;

  localparam logic [4:0] OPC_R      = 5'b01100;
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_IALU   = 5'b00100;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_OLDPC  = 2'b01;
  localparam logic [1:0] SRCA_RS1    = 2'b10;
  localparam logic [1:0] SRCB_RS2    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_CMP   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JALR   = 2'b10;
  localparam logic [1:0] WB_ALUOUT   = 2'b00;
  localparam logic [1:0] WB_MDR      = 2'b01;
  localparam logic [1:0] WB_PC       = 2'b10;
  localparam logic [1:0] WB_IMM      = 2'b11;

  typedef enum logic [3:0] {
    CLS_R, CLS_LOAD, CLS_IALU, CLS_JALR, CLS_STORE,
    CLS_BRANCH, CLS_LUI, CLS_JAL, CLS_ILLEGAL
  } instr_class_e;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       i_or_d;
    logic       illegal;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic [1:0] mem_to_reg;
  } ctrl_t;

  function automatic instr_class_e decode_class(input logic [6:0] opcode);
    instr_class_e cls;
    if (opcode[1:0] != 2'b11) begin
      cls = CLS_ILLEGAL;
    end else begin
      case (opcode[6:2])
        OPC_R:      cls = CLS_R;
        OPC_LOAD:   cls = CLS_LOAD;
        OPC_IALU:   cls = CLS_IALU;
        OPC_JALR:   cls = CLS_JALR;
        OPC_STORE:  cls = CLS_STORE;
        OPC_BRANCH: cls = CLS_BRANCH;
        OPC_LUI:    cls = CLS_LUI;
        OPC_JAL:    cls = CLS_JAL;
        default:    cls = CLS_ILLEGAL;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch-condition evaluation from funct3 and the ALU compare flags.
module branch_cond
  import riscv_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       Zero,
  input  logic       Lt,
  input  logic       Ltu,
  output logic       Take
);

  // funct3 010/011 are not branch encodings and never take
  always_comb begin
    Take = 1'b0;
    case (funct3)
      3'b000:  Take = Zero;
      3'b001:  Take = ~Zero;
      3'b100:  Take = Lt;
      3'b101:  Take = ~Lt;
      3'b110:  Take = Ltu;
      3'b111:  Take = ~Ltu;
      default: Take = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32 control FSM: Moore-decoded datapath controls, FETCH strobes
// gated by memory ready, branch PCWrite gated by the ALU flags.
module multicycle_control
  import riscv_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] Instruction_i,
  input  logic        Zero_i,
  input  logic        Lt_i,
  input  logic        Ltu_i,
  input  logic        MemReady_i,
  output logic        PCWrite_o,
  output logic        IRWrite_o,
  output logic        MemRead_o,
  output logic        MemWrite_o,
  output logic        RegWrite_o,
  output logic        IorD_o,
  output logic        IllegalInstr_o,
  output logic [1:0]  ALUSrcA_o,
  output logic [1:0]  ALUSrcB_o,
  output logic [1:0]  ALUOp_o,
  output logic [1:0]  PCSource_o,
  output logic [1:0]  MemtoReg_o,
  output logic [3:0]  State_o,
  output logic [31:0] InstrCount_o
);

  state_e       state_r;
  state_e       state_next_s;
  logic [31:0]  instr_count_r;
  logic         retire_s;
  logic         take_s;
  instr_class_e cls_s;
  ctrl_t        ctrl_s;
  ctrl_t        ctrl_out_s;
  logic         unused_instr_bits_s;

  assign cls_s = decode_class(Instruction_i[6:0]);
  assign unused_instr_bits_s = ^{Instruction_i[31:15], Instruction_i[11:7]};

  branch_cond u_branch_cond (
    .funct3 (Instruction_i[14:12]),
    .Zero   (Zero_i),
    .Lt     (Lt_i),
    .Ltu    (Ltu_i),
    .Take   (take_s)
  );

  // State register and retired-instruction counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r       <= ST_FETCH;
      instr_count_r <= 32'd0;
    end else begin
      state_r <= state_next_s;
      if (retire_s) begin
        instr_count_r <= instr_count_r + 32'd1;
      end
    end
  end

  // Next-state, retire pulse and control decode
  always_comb begin
    ctrl_s       = '0;
    state_next_s = state_r;
    retire_s     = 1'b0;
    case (state_r)
      ST_FETCH: begin
        ctrl_s.mem_read  = 1'b1;
        ctrl_s.alu_src_a = SRCA_PC;
        ctrl_s.alu_src_b = SRCB_FOUR;
        ctrl_s.alu_op    = ALUOP_ADD;
        ctrl_s.pc_source = PCSRC_ALU;
        if (MemReady_i) begin
          ctrl_s.pc_write = 1'b1;
          ctrl_s.ir_write = 1'b1;
          state_next_s    = ST_DECODE;
        end else begin
          state_next_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        ctrl_s.alu_src_a = SRCA_OLDPC;
        ctrl_s.alu_src_b = SRCB_IMM;
        ctrl_s.alu_op    = ALUOP_ADD;
        case (cls_s)
          CLS_R:      state_next_s = ST_EXEC_R;
          CLS_IALU:   state_next_s = ST_EXEC_I;
          CLS_LOAD:   state_next_s = ST_ADDR;
          CLS_STORE:  state_next_s = ST_ADDR;
          CLS_BRANCH: state_next_s = ST_BRANCH;
          CLS_JAL:    state_next_s = ST_JAL;
          CLS_JALR:   state_next_s = ST_JALR;
          CLS_LUI:    state_next_s = ST_LUI;
          default:    state_next_s = ST_TRAP;
        endcase
      end
      ST_EXEC_R: begin
        ctrl_s.alu_src_a = SRCA_RS1;
        ctrl_s.alu_src_b = SRCB_RS2;
        ctrl_s.alu_op    = ALUOP_FUNCT;
        state_next_s     = ST_ALU_WB;
      end
      ST_EXEC_I: begin
        ctrl_s.alu_src_a = SRCA_RS1;
        ctrl_s.alu_src_b = SRCB_IMM;
        ctrl_s.alu_op    = ALUOP_FUNCT;
        state_next_s     = ST_ALU_WB;
      end
      ST_ALU_WB: begin
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.mem_to_reg = WB_ALUOUT;
        state_next_s      = ST_FETCH;
        retire_s          = 1'b1;
      end
      ST_ADDR: begin
        ctrl_s.alu_src_a = SRCA_RS1;
        ctrl_s.alu_src_b = SRCB_IMM;
        ctrl_s.alu_op    = ALUOP_ADD;
        if (cls_s == CLS_STORE) begin
          state_next_s = ST_MEM_WR;
        end else begin
          state_next_s = ST_MEM_RD;
        end
      end
      ST_MEM_RD: begin
        ctrl_s.mem_read = 1'b1;
        ctrl_s.i_or_d   = 1'b1;
        if (MemReady_i) begin
          state_next_s = ST_MEM_WB;
        end else begin
          state_next_s = ST_MEM_RD;
        end
      end
      ST_MEM_WB: begin
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.mem_to_reg = WB_MDR;
        state_next_s      = ST_FETCH;
        retire_s          = 1'b1;
      end
      ST_MEM_WR: begin
        ctrl_s.mem_write = 1'b1;
        ctrl_s.i_or_d    = 1'b1;
        if (MemReady_i) begin
          state_next_s = ST_FETCH;
          retire_s     = 1'b1;
        end else begin
          state_next_s = ST_MEM_WR;
        end
      end
      ST_BRANCH: begin
        ctrl_s.alu_src_a = SRCA_RS1;
        ctrl_s.alu_src_b = SRCB_RS2;
        ctrl_s.alu_op    = ALUOP_CMP;
        ctrl_s.pc_source = PCSRC_ALUOUT;
        ctrl_s.pc_write  = take_s;
        state_next_s     = ST_FETCH;
        retire_s         = 1'b1;
      end
      ST_JAL: begin
        ctrl_s.alu_src_a  = SRCA_OLDPC;
        ctrl_s.alu_src_b  = SRCB_IMM;
        ctrl_s.pc_source  = PCSRC_ALU;
        ctrl_s.pc_write   = 1'b1;
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.mem_to_reg = WB_PC;
        state_next_s      = ST_FETCH;
        retire_s          = 1'b1;
      end
      ST_JALR: begin
        ctrl_s.alu_src_a  = SRCA_RS1;
        ctrl_s.alu_src_b  = SRCB_IMM;
        ctrl_s.pc_source  = PCSRC_JALR;
        ctrl_s.pc_write   = 1'b1;
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.mem_to_reg = WB_PC;
        state_next_s      = ST_FETCH;
        retire_s          = 1'b1;
      end
      ST_LUI: begin
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.mem_to_reg = WB_IMM;
        state_next_s      = ST_FETCH;
        retire_s          = 1'b1;
      end
      ST_TRAP: begin
        ctrl_s.illegal = 1'b1;
        state_next_s   = ST_TRAP;
      end
      default: begin
        state_next_s = ST_FETCH;
      end
    endcase
  end

  // Reset silences every control output in the cycle it is applied
  always_comb begin
    if (rst_i) begin
      ctrl_out_s = '0;
    end else begin
      ctrl_out_s = ctrl_s;
    end
  end

  assign PCWrite_o      = ctrl_out_s.pc_write;
  assign IRWrite_o      = ctrl_out_s.ir_write;
  assign MemRead_o      = ctrl_out_s.mem_read;
  assign MemWrite_o     = ctrl_out_s.mem_write;
  assign RegWrite_o     = ctrl_out_s.reg_write;
  assign IorD_o         = ctrl_out_s.i_or_d;
  assign IllegalInstr_o = ctrl_out_s.illegal;
  assign ALUSrcA_o      = ctrl_out_s.alu_src_a;
  assign ALUSrcB_o      = ctrl_out_s.alu_src_b;
  assign ALUOp_o        = ctrl_out_s.alu_op;
  assign PCSource_o     = ctrl_out_s.pc_source;
  assign MemtoReg_o     = ctrl_out_s.mem_to_reg;
  assign State_o        = state_r;
  assign InstrCount_o   = instr_count_r;

endmodule
